// File: rtl/bp_fe_pkg.sv
// Shared front-end definitions for the branch-history-table update path.
//
// The update entry carries the table index plus the two prediction-feedback
// bits. Its index width is a module parameter, so the struct is declared in
// the using module through a macro; a matching width macro sizes raw storage.
// No ports (package plus macros).

`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

`define DECLARE_BP_FE_BHT_UPDATE_S(idx_width_mp) \
    typedef struct packed {                      \
        logic [(idx_width_mp)-1:0] idx;          \
        logic                      correct;      \
        logic                      pred_taken;   \
    } bp_fe_bht_update_s

`define BP_FE_BHT_UPDATE_WIDTH(idx_width_mp) ((idx_width_mp) + 2)

package bp_fe_pkg;

    // Low PC bits below the table index are alignment/compressed bits.
    localparam int unsigned bht_pc_idx_lsb_gp = 2;

endpackage

`endif

// File: rtl/bp_fe_bht_update_queue_if.sv
// Handshake bundle between the resolved-branch producer / table write port
// and the BHT update queue.
//
// master : producer side (drives feedback, write enable, flush)
// slave  : the queue (drives ready, table write outputs, occupancy)
//
//   br_v_i / br_pc_i / br_correct_i / br_pred_taken_i : feedback in
//   br_ready_o                                        : queue can accept
//   w_en_i                                            : table write allowed
//   flush_i                                           : drop everything
//   w_v_o / idx_w_o / correct_o / pred_taken_o        : table write
//   count_o                                           : occupancy

interface bp_fe_bht_update_queue_if #(
    parameter int vaddr_width_p   = 39,
    parameter int bht_idx_width_p = 9,
    parameter int els_p           = 4
);
    logic                         br_v_i;
    logic [vaddr_width_p-1:0]     br_pc_i;
    logic                         br_correct_i;
    logic                         br_pred_taken_i;
    logic                         br_ready_o;
    logic                         w_en_i;
    logic                         flush_i;
    logic                         w_v_o;
    logic [bht_idx_width_p-1:0]   idx_w_o;
    logic                         correct_o;
    logic                         pred_taken_o;
    logic [$clog2(els_p):0]       count_o;

    modport master (
        output br_v_i, br_pc_i, br_correct_i, br_pred_taken_i, w_en_i, flush_i,
        input  br_ready_o, w_v_o, idx_w_o, correct_o, pred_taken_o, count_o
    );

    modport slave (
        input  br_v_i, br_pc_i, br_correct_i, br_pred_taken_i, w_en_i, flush_i,
        output br_ready_o, w_v_o, idx_w_o, correct_o, pred_taken_o, count_o
    );
endinterface

// File: rtl/bp_fe_bht_update_fifo.sv
// Generic circular buffer with read/write pointers and an occupancy count.
// Callers must not enqueue when full or dequeue when empty. clr_i empties the
// buffer and returns both pointers to zero; storage contents are not cleared.
//
//   clk_i, reset_i : clock, synchronous active-high reset
//   clr_i          : empty the buffer (wins over enq/deq)
//   enq_i, data_i  : write data_i at the tail
//   deq_i          : retire the head
//   data_o         : head entry (stale when empty)
//   count_o        : occupancy 0..els_p

module bp_fe_bht_update_fifo #(
    parameter int width_p = 11,
    parameter int els_p   = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clr_i,
    input  logic                     enq_i,
    input  logic                     deq_i,
    input  logic [width_p-1:0]       data_i,
    output logic [width_p-1:0]       data_o,
    output logic [$clog2(els_p):0]   count_o
);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;

    // els_p is a power of two, so pointer wrap is plain overflow.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (clr_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq_i) wptr_d = wptr_q + ptr_w_lp'(1);
            if (deq_i) rptr_d = rptr_q + ptr_w_lp'(1);
            case ({enq_i, deq_i})
                2'b10:   count_d = count_q + cnt_w_lp'(1);
                2'b01:   count_d = count_q - cnt_w_lp'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_i & ~clr_i) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/bp_fe_bht_update_queue.sv
// In-order buffer of resolved-branch feedback feeding the branch history
// table write port. The table index is cut from the branch PC on acceptance;
// at most one update drains per cycle when the front end allows a write.
// Flush discards queued and incoming updates; there is no enqueue-to-output
// bypass, so an accepted branch is visible one cycle later at the earliest.
//
//   clk_i, reset_i : clock, synchronous active-high reset
//   q_if (slave)   : feedback handshake, table write, flush, occupancy

module bp_fe_bht_update_queue
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p   = 39,
    parameter int bht_idx_width_p = 9,
    parameter int els_p           = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    bp_fe_bht_update_queue_if.slave   q_if
);
    localparam int cnt_w_lp   = $clog2(els_p) + 1;
    localparam int entry_w_lp = `BP_FE_BHT_UPDATE_WIDTH(bht_idx_width_p);
    localparam int idx_msb_lp = bht_idx_width_p + bht_pc_idx_lsb_gp - 1;

    `DECLARE_BP_FE_BHT_UPDATE_S(bht_idx_width_p);

    bp_fe_bht_update_s     enq_entry, head_entry;
    logic [entry_w_lp-1:0] head_raw;
    logic [cnt_w_lp-1:0]   count;
    logic                  full, empty, ready, w_v, enq, deq;

    // PC bits outside the index window are intentionally dropped.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{q_if.br_pc_i[vaddr_width_p-1:idx_msb_lp+1],
                              q_if.br_pc_i[bht_pc_idx_lsb_gp-1:0]};

    always_comb begin
        enq_entry            = '0;
        enq_entry.idx        = q_if.br_pc_i[idx_msb_lp:bht_pc_idx_lsb_gp];
        enq_entry.correct    = q_if.br_correct_i;
        enq_entry.pred_taken = q_if.br_pred_taken_i;
    end

    // Ready looks only at registered occupancy, so a full queue refuses
    // input even in a cycle where it also drains.
    assign full  = (count == cnt_w_lp'(els_p));
    assign empty = (count == '0);
    assign ready = ~full & ~q_if.flush_i;
    assign w_v   = ~empty & q_if.w_en_i & ~q_if.flush_i;
    assign enq   = q_if.br_v_i & ready;
    assign deq   = w_v;

    bp_fe_bht_update_fifo #(
        .width_p (entry_w_lp),
        .els_p   (els_p)
    ) fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (q_if.flush_i),
        .enq_i   (enq),
        .deq_i   (deq),
        .data_i  (enq_entry),
        .data_o  (head_raw),
        .count_o (count)
    );

    assign head_entry        = bp_fe_bht_update_s'(head_raw);
    assign q_if.br_ready_o   = ready;
    assign q_if.w_v_o        = w_v;
    assign q_if.idx_w_o      = head_entry.idx;
    assign q_if.correct_o    = head_entry.correct;
    assign q_if.pred_taken_o = head_entry.pred_taken;
    assign q_if.count_o      = count;

endmodule

// File: tb/tb_bp_fe_bht_update_queue.sv
module tb_bp_fe_bht_update_queue;
    localparam int VA = 39;
    localparam int IW = 9;
    localparam int E  = 4;

    logic clk_i = 1'b0;
    logic reset_i;

    always #5 clk_i = ~clk_i;

    bp_fe_bht_update_queue_if #(.vaddr_width_p(VA), .bht_idx_width_p(IW), .els_p(E)) q_if ();

    bp_fe_bht_update_queue #(.vaddr_width_p(VA), .bht_idx_width_p(IW), .els_p(E)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .q_if    (q_if)
    );

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          c;
        logic          p;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle against
    // the occupancy model, then advance the model past the edge.
    task automatic cyc(input logic v, input logic [VA-1:0] pc, input logic c, input logic p,
                       input logic wen, input logic fl, input logic rst);
        logic er, ew;
        exp_t e, h;
        q_if.br_v_i          = v;
        q_if.br_pc_i         = pc;
        q_if.br_correct_i    = c;
        q_if.br_pred_taken_i = p;
        q_if.w_en_i          = wen;
        q_if.flush_i         = fl;
        reset_i              = rst;
        er = (m_cnt != E) && !fl;
        ew = (m_cnt != 0) && wen && !fl;
        @(negedge clk_i);
        if (!rst) begin
            chk("br_ready", {31'b0, q_if.br_ready_o}, {31'b0, er});
            chk("w_v",      {31'b0, q_if.w_v_o},      {31'b0, ew});
            chk("count",    32'(q_if.count_o),        32'(m_cnt));
            if (ew) begin
                chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    h = sb.pop_front();
                    chk("idx_w",      32'(q_if.idx_w_o),        32'(h.idx));
                    chk("correct",    {31'b0, q_if.correct_o},    {31'b0, h.c});
                    chk("pred_taken", {31'b0, q_if.pred_taken_o}, {31'b0, h.p});
                end
            end
            if (er && v) begin
                e.idx = pc[IW+1:2];
                e.c   = c;
                e.p   = p;
                sb.push_back(e);
            end
        end
        @(posedge clk_i);
        #1;
        if (rst || fl) begin
            m_cnt = 0;
            sb.delete();
        end else begin
            m_cnt = m_cnt + ((er && v) ? 1 : 0) - (ew ? 1 : 0);
        end
    endtask

    task automatic enq_idx(input int idx, input logic wen);
        logic [VA-1:0] pc;
        pc = VA'(idx) << 2;
        pc[VA-1:IW+2] = VA'($urandom) & ((VA'(1) << (VA-IW-2)) - 1);
        pc[1:0] = 2'($urandom);
        cyc(1'b1, pc, 1'($urandom), 1'($urandom), wen, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic wen);
        cyc(1'b0, '0, 1'b0, 1'b0, wen, 1'b0, 1'b0);
    endtask

    initial begin
        q_if.br_v_i = 0; q_if.br_pc_i = '0; q_if.br_correct_i = 0;
        q_if.br_pred_taken_i = 0; q_if.w_en_i = 0; q_if.flush_i = 0;
        reset_i = 1;

        // Reset
        cyc(0, '0, 0, 0, 0, 0, 1);
        cyc(0, '0, 0, 0, 0, 0, 1);
        idle(1);

        // Single update, pc=0x1008 -> idx 0x002
        cyc(1, VA'(39'h1008), 0, 1, 1, 0, 0);
        idle(1);
        idle(1);

        // Fill to full, refuse a fifth, then drain in order
        for (int i = 1; i <= 4; i++) enq_idx(i, 0);
        enq_idx(5, 0);
        for (int i = 0; i < 5; i++) idle(1);

        // Full with simultaneous dequeue: enqueue refused, count 3 after
        for (int i = 1; i <= 4; i++) enq_idx(i + 16, 0);
        enq_idx(99, 1);
        idle(0);
        for (int i = 0; i < 3; i++) idle(1);

        // Steady stream, pointers wrap repeatedly
        for (int i = 0; i < 20; i++) enq_idx(int'($urandom_range(0, (1 << IW) - 1)), 1);
        idle(1);
        idle(1);

        // Flush with a concurrent valid
        for (int i = 1; i <= 3; i++) enq_idx(i + 40, 0);
        cyc(1, VA'(39'h2468), 1, 1, 1, 1, 0);
        idle(1);
        enq_idx(9'h1ab, 1);
        idle(1);
        idle(1);

        // Mid-operation reset
        enq_idx(7, 0);
        enq_idx(8, 0);
        cyc(0, '0, 0, 0, 0, 0, 1);
        idle(1);
        idle(1);
        enq_idx(9'h0f3, 1);
        idle(1);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bp_fe_bht_update_queue.md
Name: bp_fe_bht_update_queue

Overview:
- Upstream feeder for the front-end branch history table's write port.
- Accepts resolved-branch feedback from the backend/commit path over a valid/ready handshake.
- Extracts the table index from the branch PC and buffers updates in a small in-order queue.
- Drains at most one update per cycle to the history table's write interface when the front end permits writes; a flush discards all pending updates.

Parameters:
- vaddr_width_p, 39, branch PC width.
- bht_idx_width_p, 9, history table index width; must match the table.
- els_p, 4, queue depth; power of two, minimum 2.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- br_v_i  in  1  resolved-branch feedback valid.
- br_pc_i  in  vaddr_width_p  PC of the resolved branch.
- br_correct_i  in  1  prediction was correct.
- br_pred_taken_i  in  1  direction that was predicted.
- br_ready_o  out  1  queue can accept feedback this cycle.
- w_en_i  in  1  front end permits a table write this cycle.
- flush_i  in  1  discard all queued and incoming updates.
- w_v_o  out  1  table write valid.
- idx_w_o  out  bht_idx_width_p  table write index.
- correct_o  out  1  correct flag for the write.
- pred_taken_o  out  1  predicted direction for the write.
- count_o  out  $clog2(els_p)+1  occupancy.

Behaviour:
- Clock and reset: one clock `clk_i`; reset `reset_i` is synchronous and active-high.
- Index extraction: idx = br_pc_i[bht_idx_width_p+1:2], dropping the 2 compressed/align bits. The index is computed on enqueue and stored; the PC is not stored.
- Entry contents: {idx, correct, pred_taken}, width bht_idx_width_p+2.
- Storage: circular buffer of els_p entries with rptr and wptr, each $clog2(els_p) bits wide and wrapping modulo els_p. A count register runs 0..els_p.
- br_ready_o = (count != els_p) & ~flush_i.
- Enqueue: occurs when br_v_i & br_ready_o. The entry is written at wptr, and wptr increments.
- Full queue: no enqueue, even if a dequeue happens the same cycle. br_ready_o depends only on registered count and flush_i.
- Write outputs:
  - w_v_o = (count != 0) & w_en_i & ~flush_i.
  - idx_w_o, correct_o and pred_taken_o always show the head entry at rptr.
  - When the queue is empty they hold the last head contents; their value is don't-care and must not be checked.
- Dequeue: occurs exactly when w_v_o is high; rptr increments.
- No bypass: a branch accepted in cycle N appears on w_v_o no earlier than cycle N+1. Latency is 1 cycle when the queue is empty and w_en_i is high.
- Simultaneous enqueue and dequeue: count is unchanged; both pointers advance.
- Ordering: strict FIFO. Updates reach the table in acceptance order, because the table's global history shift depends on it.
- Flush (flush_i=1):
  - Next cycle: count=0 and rptr=wptr=0.
  - Same cycle: no enqueue, no dequeue, w_v_o=0.
  - Flush takes priority over everything except reset.
- Backpressure from w_en_i=0: the head is held and the pointers are stable.
- Reset values: count_o=0, w_v_o=0, br_ready_o=1 (when flush_i=0), pointers 0. Storage contents are not reset.
- Reset mid-operation: all pending updates are lost, with the same outcome as a flush.

Decomposition:
- bp_fe_pkg: typedef bp_fe_bht_update_s {idx, correct, pred_taken}, parameterised by width via macro declare/width helpers. Also a constant for the PC index low-bit offset (2).
- Sub-module bp_fe_bht_update_fifo: generic pointer/count circular buffer with enq/deq/clr. The top level handles index extraction, ready/valid gating and flush priority.

Test Plan:
- Single update: reset, w_en_i=1; br_v_i=1 with pc=0x1008, correct=0, pred_taken=1 → next cycle w_v_o=1, idx_w_o=0x002, correct_o=0, pred_taken_o=1; count_o returns to 0.
- Fill to full: w_en_i=0, enqueue 4 updates with idx 1..4 → count_o=4, br_ready_o=0, and a 5th br_v_i is not accepted. Then w_en_i=1 → w_v_o high for 4 consecutive cycles with idx 1,2,3,4 in order.
- Full with simultaneous dequeue: count=4, w_en_i=1, br_v_i=1 → enqueue refused, count_o=3 next cycle, br_ready_o=1.
- Steady stream: one branch per cycle with w_en_i=1 for 20 cycles → count_o stays at 1 and the outputs match the inputs delayed 1 cycle. The pointers wrap past els_p with no loss.
- Flush: count=3, assert flush_i together with br_v_i=1 → br_ready_o=0 and w_v_o=0 that cycle; next cycle count_o=0, w_v_o=0. A later single update emerges with its own idx, not stale data.
- Mid-operation reset: count=2, reset_i for 1 cycle → count_o=0, w_v_o=0, br_ready_o=1; no stale writes emerge afterwards.
